seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display with decimal points.

---
 rtl/seven_seg_pkg.sv | 54 +++++
 rtl/seven_seg_lz_mask.sv | 28 ++
 rtl/seven_seg_scan_driver.sv | 136 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared glyph table and helpers for the multiplexed seven-segment driver.
// Glyph constants are active-high, bit order {g,f,e,d,c,b,a} with a = bit 0.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // What the output stage is doing with the current digit slot.
    typedef enum logic [1:0] {
        SLOT_OFF,    // scanning disabled, display dark
        SLOT_DEAD,   // anti-ghost gap at the start of each slot
        SLOT_DRIVE   // active digit lit (or deliberately dark)
    } slot_phase_e;

    // Hex nibble to active-high segment pattern.
    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seven_seg_lz_mask.sv
// Leading-zero suppression mask: bit i is set when digit i and every digit
// above it are zero with no decimal point requested. Digit 0 is never masked
// so a value of zero still shows a single "0".
module seven_seg_lz_mask
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   mask
);

    logic zero_above;

    // Walk from the most significant digit down, tracking whether everything so far is empty.
    always_comb begin
        zero_above = 1'b1;
        mask       = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (digits[4*i +: 4] == 4'h0) & ~dp[i];
            if (i != 0) begin
                mask[i] = zero_above;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-digit blanking,
// optional leading-zero suppression, programmable scan rate and a one-cycle
// dead slot between digits to stop ghosting on the anode transitions.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int LZ_SUPPRESS = 1,
    parameter int SEG_ACT_LO  = 1,
    parameter int AN_ACT_LO   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [7:0]            SEG_OFF = (SEG_ACT_LO != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LO != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [NUM_DIGITS-1:0] AN_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        dig_idx;
    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   suppress;
    slot_phase_e             phase;
    logic [3:0]              cur_nibble;
    logic                    cur_dark;
    logic [7:0]              seg_ah;
    logic [NUM_DIGITS-1:0]   an_ah;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    seven_seg_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .digits (digits_sh),
        .dp     (dp_sh),
        .mask   (lz_mask)
    );

    assign suppress = (LZ_SUPPRESS != 0) ? lz_mask : '0;

    // Slot divider and digit index; both freeze while scanning is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (en) begin
            if (div_cnt == CNT_LAST) begin
                div_cnt <= '0;
                dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Frame strobe coincides with the edge that wraps the last digit back to digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= 1'b0;
        end else begin
            frame <= en && (div_cnt == CNT_LAST) && (dig_idx == IDX_LAST);
        end
    end

    // Shadow registers decouple the pins from datapath updates; capture works even when dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_sh <= '0;
            dp_sh     <= '0;
            blank_sh  <= '1;
        end else if (load) begin
            digits_sh <= digits_in;
            dp_sh     <= dp_in;
            blank_sh  <= blank_in;
        end
    end

    // Classify the current cycle of the slot and pick the glyph for the active digit.
    always_comb begin
        if (!en) begin
            phase = SLOT_OFF;
        end else if (div_cnt == '0) begin
            phase = SLOT_DEAD;
        end else begin
            phase = SLOT_DRIVE;
        end
        cur_nibble = digits_sh[4*dig_idx +: 4];
        cur_dark   = blank_sh[dig_idx] | suppress[dig_idx];
    end

    // Build active-high segment/anode patterns, then apply the board polarity.
    always_comb begin
        seg_ah = 8'h00;
        an_ah  = '0;
        if (phase == SLOT_DRIVE) begin
            an_ah = AN_ONE << dig_idx;
            if (!cur_dark) begin
                seg_ah = {dp_sh[dig_idx], hex2seg(cur_nibble)};
            end
        end
        seg_next = (SEG_ACT_LO != 0) ? ~seg_ah : seg_ah;
        an_next  = (AN_ACT_LO != 0) ? ~an_ah : an_ah;
    end

    // Register the pin drive so segment and anode changes land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for the seven-segment scan driver: 4 digits, 4 clocks per
// slot, active-low segments and anodes.
module tb_seven_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int checks;
    int fails;
    int ph;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (4),
        .LZ_SUPPRESS (1),
        .SEG_ACT_LO  (1),
        .AN_ACT_LO   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .seg       (seg),
        .an        (an),
        .frame     (frame)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic en_v, input logic load_v, input logic [15:0] d,
                                 input logic [3:0] p, input logic [3:0] b);
        en        = en_v;
        load      = load_v;
        digits_in = d;
        dp_in     = p;
        blank_in  = b;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_an,
                               input logic [7:0] exp_seg, input logic exp_frame);
        checks++;
        assert (an === exp_an) else begin
            fails++;
            $error("[TB] FAIL %s an: got %h expected %h", tag, an, exp_an);
        end
        checks++;
        assert (seg === exp_seg) else begin
            fails++;
            $error("[TB] FAIL %s seg: got %h expected %h", tag, seg, exp_seg);
        end
        checks++;
        assert (frame === exp_frame) else begin
            fails++;
            $error("[TB] FAIL %s frame: got %b expected %b", tag, frame, exp_frame);
        end
    endtask

    // One clock: ph is the scan position before the edge (slot = ph/4, cycle in slot = ph%4).
    // segs packs the expected lit pattern per digit, digit 0 in [7:0].
    task automatic stepCycle(input logic [31:0] segs, input string tag);
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic       exp_frame;
        int         idx;
        int         pos;
        @(posedge clk);
        if (en) begin
            idx       = ph / 4;
            pos       = ph % 4;
            exp_frame = (ph == 15);
            if (pos == 0) begin
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
            end else begin
                exp_an  = ~(4'b0001 << idx);
                exp_seg = segs[8*idx +: 8];
            end
            ph = (ph + 1) % 16;
        end else begin
            exp_an    = 4'hF;
            exp_seg   = 8'hFF;
            exp_frame = 1'b0;
        end
        @(negedge clk);
        load = 1'b0;
        checkOutput(tag, exp_an, exp_seg, exp_frame);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        ph     = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0);

        // Reset values, then a dark idle period with scanning disabled.
        @(negedge clk);
        checkOutput("reset", 4'hF, 8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) stepCycle(32'hFFFF_FFFF, "idle_en0");

        // Plain scan of 1234 over two frames.
        $display("[TB] scan 1234");
        applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
        for (int i = 0; i < 32; i++) stepCycle(32'hF9A4_B099, "scan_1234");

        // Leading-zero suppression.
        $display("[TB] leading zeros");
        applyStimulus(1'b1, 1'b1, 16'h0070, 4'b0000, 4'h0);
        for (int i = 0; i < 16; i++) stepCycle(32'hFFFF_F8C0, "lz_0070");
        applyStimulus(1'b1, 1'b1, 16'h0000, 4'b0000, 4'h0);
        for (int i = 0; i < 16; i++) stepCycle(32'hFFFF_FFC0, "lz_0000");
        applyStimulus(1'b1, 1'b1, 16'h0070, 4'b1000, 4'h0);
        for (int i = 0; i < 16; i++) stepCycle(32'h40C0_F8C0, "lz_dp3");

        // Load ABCD in the middle of digit 2's slot.
        $display("[TB] mid-slot load");
        for (int i = 0; i < 10; i++) stepCycle(32'h40C0_F8C0, "pre_load");
        applyStimulus(1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0);
        stepCycle(32'h40C0_F8C0, "load_edge");
        for (int i = 0; i < 11; i++) stepCycle(32'h8883_C6A1, "post_load");

        // Pause mid digit 1, load while dark, then resume.
        $display("[TB] enable pause");
        applyStimulus(1'b0, 1'b0, 16'hABCD, 4'h0, 4'h0);
        stepCycle(32'h8883_C6A1, "paused");
        stepCycle(32'h8883_C6A1, "paused");
        applyStimulus(1'b0, 1'b1, 16'h9876, 4'b0010, 4'b1000);
        stepCycle(32'hFF80_7882, "paused_load");
        stepCycle(32'hFF80_7882, "paused");
        stepCycle(32'hFF80_7882, "paused");
        applyStimulus(1'b1, 1'b0, 16'h9876, 4'b0010, 4'b1000);
        for (int i = 0; i < 5; i++) stepCycle(32'hFF80_7882, "resume");

        // Asynchronous reset between clock edges while a digit is lit.
        $display("[TB] async reset");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'hF, 8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ph    = 0;
        for (int i = 0; i < 16; i++) stepCycle(32'hFFFF_FFFF, "post_reset_blank");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
